r_decode_stage: RTL

//  Registered, handshaked R-format decode stage for the LEGv8 control unit.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/r_field_decode.sv | 62 ++++++
 rtl/r_decode_stage.sv | 104 ++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-unit definitions: control-word layout, ALU function codes and
// the R-format opcodes recognised by the decode stage.
package ctrl_pkg;

  localparam int CW_W = 33;

  // Bit positions of the most-probed control-word fields
  localparam int CW_BS_BIT        = 31;
  localparam int CW_FS_LSB        = 26;
  localparam int CW_RF_W_BIT      = 9;
  localparam int CW_STATUS_LD_BIT = 2;

  localparam logic [4:0] FS_LEFT      = 5'b10000;
  localparam logic [4:0] FS_RIGHT     = 5'b10100;
  localparam logic [4:0] FS_MUL_START = 5'b11000;
  localparam logic [4:0] FS_MUL_STEP  = 5'b11100;

  localparam logic [1:0] PC_FS_INC = 2'b01;

  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_ANDS = 11'b11101010000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic       alu_en;
    logic       alu_bs;
    logic [4:0] alu_fs;
    logic       rf_b_en;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       rf_w;
    logic       ram_en;
    logic       ram_w;
    logic       pc_en;
    logic [1:0] pc_fs;
    logic       pc_is;
    logic       status_ld;
    logic [1:0] next_state;
  } cw_t;

endpackage

// File: rtl/r_field_decode.sv
// Combinational R-format field decode: instruction -> control word, K constant,
// illegal flag and MUL detect. MUL yields its first expansion word here.
module r_field_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       instr_i,
  output cw_t               cw_o,
  output logic [DATA_W-1:0] k_o,
  output logic              illegal_o,
  output logic              is_mul_o
);

  logic [10:0] op;
  logic [4:0]  rm, rn, rd;
  logic [5:0]  shamt;
  logic        legal;
  logic        k_sel;

  assign op    = instr_i[31:21];
  assign rm    = instr_i[20:16];
  assign shamt = instr_i[15:10];
  assign rn    = instr_i[9:5];
  assign rd    = instr_i[4:0];

  assign legal = op inside {OP_AND, OP_ADD, OP_ORR, OP_ADDS, OP_EOR, OP_SUB,
                            OP_ANDS, OP_SUBS, OP_LSR, OP_LSL, OP_MUL};
  assign k_sel = op[1] & op[3];

  always_comb begin
    cw_o            = '0;
    cw_o.alu_en     = 1'b1;
    cw_o.alu_bs     = k_sel;
    cw_o.alu_fs     = op[1] ? (op[0] ? FS_LEFT : FS_RIGHT)
                            : {1'b0,
                               op[3] | (op[9] & op[8]),
                               (~op[9] & op[8] & op[3]) | (op[9] & ~op[8] & ~op[3]),
                               op[9] & op[3],
                               1'b0};
    cw_o.rf_b_en    = 1'b0;
    cw_o.sa         = rn;
    cw_o.sb         = rm;
    cw_o.da         = rd;
    cw_o.rf_w       = legal;
    cw_o.pc_fs      = PC_FS_INC;
    cw_o.status_ld  = legal & op[8];
    cw_o.next_state = 2'b00;
    k_o             = k_sel ? DATA_W'(shamt) : '0;
    is_mul_o        = (op == OP_MUL);
    illegal_o       = ~legal;
    // MUL: first word of the expansion; write-back happens only on the last step
    if (is_mul_o) begin
      cw_o.alu_fs    = FS_MUL_START;
      cw_o.alu_bs    = 1'b0;
      cw_o.rf_w      = 1'b0;
      cw_o.status_ld = 1'b0;
      k_o            = '0;
    end
  end

endmodule

// File: rtl/r_decode_stage.sv
// Registered valid/ready R-format decode stage; expands MUL into MUL_STEPS words.
// state | meaning: ST_IDLE accepts instructions; ST_MUL_RUN issues remaining MUL steps.
module r_decode_stage
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MUL_STEPS = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] k,
  output logic              illegal,
  output logic              busy
);

  localparam int CNT_W = $clog2(MUL_STEPS);

  cw_t               dec_cw;
  logic [DATA_W-1:0] dec_k;
  logic              dec_illegal, dec_is_mul;

  state_t            state_q;
  logic [CNT_W-1:0]  left_q;
  cw_t               cw_q;
  logic [DATA_W-1:0] k_q;
  logic              valid_q, illegal_q, busy_q;
  logic              accept, drain;
  cw_t               step_cw_d;

  r_field_decode #(.DATA_W(DATA_W)) u_field_decode (
    .instr_i   (instr),
    .cw_o      (dec_cw),
    .k_o       (dec_k),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_is_mul)
  );

  assign in_ready = (state_q == ST_IDLE) & (~valid_q | cw_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = valid_q & cw_ready;

  // left_q counts words still to issue after the one on the output
  always_comb begin
    step_cw_d        = cw_q;
    step_cw_d.alu_fs = FS_MUL_STEP;
    step_cw_d.rf_w   = (left_q == CNT_W'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      left_q    <= '0;
      cw_q      <= '0;
      k_q       <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cw_q      <= dec_cw;
            k_q       <= dec_k;
            illegal_q <= dec_illegal;
            valid_q   <= 1'b1;
            if (dec_is_mul) begin
              state_q <= ST_MUL_RUN;
              busy_q  <= 1'b1;
              left_q  <= CNT_W'(MUL_STEPS - 1);
            end
          end else if (drain) begin
            valid_q <= 1'b0;
          end
        end
        ST_MUL_RUN: begin
          if (drain) begin
            if (left_q == '0) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              cw_q   <= step_cw_d;
              left_q <= left_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cw       = cw_q;
  assign k        = k_q;
  assign cw_valid = valid_q;
  assign illegal  = illegal_q;
  assign busy     = busy_q;

endmodule
